// File: rtl/fbs_ctrl_if.sv
// Requester-side handshake bundle for fbs_ctrl: A = call/return unit, B = trap unit.
// req/op held until the matching ack; err and rd_valid qualify that ack.
interface fbs_ctrl_if;
    logic req_a;
    logic op_a;
    logic req_b;
    logic op_b;
    logic ack_a;
    logic ack_b;
    logic err;
    logic rd_valid;

    modport master (
        output req_a, op_a, req_b, op_b,
        input  ack_a, ack_b, err, rd_valid
    );

    modport slave (
        input  req_a, op_a, req_b, op_b,
        output ack_a, ack_b, err, rd_valid
    );
endinterface

// File: rtl/fbs_ctrl.sv
// Round-robin sequencer for the f-register backup stack; FBS_CTRL_STATS_EN adds hwm_o/rej_cnt_o.
// Ack 2 cycles after req for backup, 2+RD_LAT for restore; requests wait outside IDLE, never dropped.
module fbs_ctrl #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DEPTH_W = 5,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    fbs_ctrl_if.slave          bus,
    output logic               fbs_backup_o,
    output logic               fbs_restore_o,
    output logic               fbs_sel_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               full_o,
    output logic               empty_o
`ifdef FBS_CTRL_STATS_EN
    ,
    output logic [DEPTH_W-1:0] hwm_o,
    output logic [7:0]         rej_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    localparam logic [DEPTH_W-1:0] DEPTH_V = DEPTH_W'(DEPTH);
    localparam logic [1:0]         LAT_M1  = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

    state_t             state_q;
    logic [DEPTH_W-1:0] depth_q;
    logic               rr_q;
    logic               id_q;
    logic               op_q;
    logic [1:0]         cnt_q;
    logic               ack_a_q;
    logic               ack_b_q;
    logic               err_q;
    logic               rd_valid_q;
    logic               backup_q;
    logic               restore_q;
    logic               sel_q;

    logic               req_a_m;
    logic               req_b_m;
    logic               gnt_vld_d;
    logic               gnt_id_d;
    logic               gnt_op_d;
    logic               full;
    logic               empty;
    logic               push_ok;
    logic               pop_ok;
    logic [DEPTH_W-1:0] depth_inc;

    assign full      = (depth_q == DEPTH_V);
    assign empty     = (depth_q == '0);
    assign depth_inc = depth_q + DEPTH_W'(1);
    assign push_ok   = (state_q == GRANT) && !op_q && !full;
    assign pop_ok    = (state_q == GRANT) &&  op_q && !empty;

    // A requester still holding req during its own ack cycle is not re-granted.
    always_comb begin
        req_a_m   = bus.req_a & ~ack_a_q;
        req_b_m   = bus.req_b & ~ack_b_q;
        gnt_vld_d = req_a_m | req_b_m;
        gnt_id_d  = (req_a_m && req_b_m) ? rr_q : req_b_m;
        gnt_op_d  = gnt_id_d ? bus.op_b : bus.op_a;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            depth_q    <= '0;
            rr_q       <= 1'b0;
            id_q       <= 1'b0;
            op_q       <= 1'b0;
            cnt_q      <= 2'd0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            backup_q   <= 1'b0;
            restore_q  <= 1'b0;
            sel_q      <= 1'b0;
        end else begin
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            backup_q   <= 1'b0;
            restore_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        id_q    <= gnt_id_d;
                        op_q    <= gnt_op_d;
                        rr_q    <= ~gnt_id_d;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (push_ok) begin
                        backup_q <= 1'b1;
                        sel_q    <= id_q;
                        depth_q  <= depth_inc;
                        ack_a_q  <= ~id_q;
                        ack_b_q  <= id_q;
                        state_q  <= IDLE;
                    end else if (pop_ok) begin
                        restore_q <= 1'b1;
                        depth_q   <= depth_q - DEPTH_W'(1);
                        if (RD_LAT == 0) begin
                            ack_a_q    <= ~id_q;
                            ack_b_q    <= id_q;
                            rd_valid_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            cnt_q   <= LAT_M1;
                            state_q <= RDWAIT;
                        end
                    end else begin
                        // overflow or underflow: reject without touching the stack
                        ack_a_q <= ~id_q;
                        ack_b_q <= id_q;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                RDWAIT: begin
                    if (cnt_q == 2'd0) begin
                        ack_a_q    <= ~id_q;
                        ack_b_q    <= id_q;
                        rd_valid_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FBS_CTRL_STATS_EN
    logic [DEPTH_W-1:0] hwm_q;
    logic [7:0]         rej_q;
    logic               rej;

    assign rej = (state_q == GRANT) && !push_ok && !pop_ok;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hwm_q <= '0;
            rej_q <= 8'd0;
        end else begin
            if (push_ok && (depth_inc > hwm_q)) begin
                hwm_q <= depth_inc;
            end
            if (rej && (rej_q != 8'hFF)) begin
                rej_q <= rej_q + 8'd1;
            end
        end
    end

    assign hwm_o     = hwm_q;
    assign rej_cnt_o = rej_q;
`endif

    assign bus.ack_a    = ack_a_q;
    assign bus.ack_b    = ack_b_q;
    assign bus.err      = err_q;
    assign bus.rd_valid = rd_valid_q;
    assign fbs_backup_o  = backup_q;
    assign fbs_restore_o = restore_q;
    assign fbs_sel_o     = sel_q;
    assign depth_o       = depth_q;
    assign full_o        = full;
    assign empty_o       = empty;

endmodule

// File: tb/tb_fbs_ctrl.sv
// Directed bench for fbs_ctrl with a behavioural stack model and a LIFO expectation queue.
module tb_fbs_ctrl;
    localparam int DEPTH   = 16;
    localparam int DEPTH_W = 5;
    localparam int RD_LAT  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fbs_ctrl_if ifc ();

    logic               fbs_backup;
    logic               fbs_restore;
    logic               fbs_sel;
    logic [DEPTH_W-1:0] depth;
    logic               full;
    logic               empty;
`ifdef FBS_CTRL_STATS_EN
    logic [DEPTH_W-1:0] hwm;
    logic [7:0]         rej_cnt;
`endif

    fbs_ctrl #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W), .RD_LAT(RD_LAT)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .bus           (ifc),
        .fbs_backup_o  (fbs_backup),
        .fbs_restore_o (fbs_restore),
        .fbs_sel_o     (fbs_sel),
        .depth_o       (depth),
        .full_o        (full),
        .empty_o       (empty)
`ifdef FBS_CTRL_STATS_EN
        ,
        .hwm_o         (hwm),
        .rej_cnt_o     (rej_cnt)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural stack: captures on the strobe cycle, restored data valid RD_LAT=1 later.
    logic [255:0] mem [0:DEPTH-1];
    int           sp;
    logic [255:0] rd_dat;
    logic [255:0] frame_a;
    logic [255:0] frame_b;
    logic [255:0] shadow [$];

    always @(posedge clk) begin
        if (!rst_n) begin
            sp <= 0;
        end else begin
            if (fbs_backup) begin
                mem[sp] <= fbs_sel ? frame_b : frame_a;
                sp      <= sp + 1;
            end
            if (fbs_restore) begin
                rd_dat <= mem[sp-1];
                sp     <= sp - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("one ack", ifc.ack_a & ifc.ack_b, 0);
            chk("one strobe", fbs_backup & fbs_restore, 0);
            chk("full decode", full, depth == DEPTH_W'(DEPTH));
            chk("empty decode", empty, depth == '0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ifc.req_a = 1'b0;
        ifc.req_b = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        shadow.delete();
    endtask

    // One complete operation; checks latency, err, strobes, LIFO data; holds req through the ack cycle.
    task automatic do_op(input bit id, input bit op, input bit exp_err, input logic [255:0] val,
                         input string tag);
        int n;
        bit got;
        bit saw_bk;
        bit saw_rs;
        logic [255:0] exp_dat;
        int exp_lat;
        exp_lat = (op && !exp_err) ? 2 + RD_LAT : 2;
        if (!op) begin
            if (id) frame_b = val; else frame_a = val;
        end
        if (id) begin ifc.op_b = op; ifc.req_b = 1'b1; end
        else    begin ifc.op_a = op; ifc.req_a = 1'b1; end
        n = 0; got = 0; saw_bk = 0; saw_rs = 0;
        while (!got && n < 12) begin
            tick();
            n++;
            if (fbs_backup)  saw_bk = 1;
            if (fbs_restore) saw_rs = 1;
            if (id ? ifc.ack_b : ifc.ack_a) got = 1;
        end
        chk({tag, " ack seen"}, got, 1);
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " err"}, ifc.err, exp_err);
        chk({tag, " other ack"}, id ? ifc.ack_a : ifc.ack_b, 0);
        if (!op) begin
            chk({tag, " backup strobe"}, saw_bk, !exp_err);
            if (!exp_err) begin
                chk({tag, " sel"}, fbs_sel, id);
                shadow.push_back(val);
            end
        end else begin
            chk({tag, " restore strobe"}, saw_rs, !exp_err);
            chk({tag, " rd_valid"}, ifc.rd_valid, !exp_err);
            if (!exp_err) begin
                exp_dat = shadow.pop_back();
                chk({tag, " data"}, rd_dat, exp_dat);
            end
        end
        tick();
        if (id) ifc.req_b = 1'b0; else ifc.req_a = 1'b0;
    endtask

    initial begin
        int acks;
        bit exp_id;
        ifc.req_a = 1'b0; ifc.op_a = 1'b0;
        ifc.req_b = 1'b0; ifc.op_b = 1'b0;
        frame_a = '0; frame_b = '0;

        // reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst ack_a", ifc.ack_a, 0);
        chk("rst ack_b", ifc.ack_b, 0);
        chk("rst err", ifc.err, 0);
        chk("rst rd_valid", ifc.rd_valid, 0);
        chk("rst backup", fbs_backup, 0);
        chk("rst restore", fbs_restore, 0);
        chk("rst sel", fbs_sel, 0);
        chk("rst depth", depth, 0);
        chk("rst empty", empty, 1);
        chk("rst full", full, 0);
        rst_n = 1'b1;
        shadow.delete();

        // single A backup, cycle by cycle
        frame_a = {8{32'hA1A1_0001}};
        ifc.op_a = 1'b0; ifc.req_a = 1'b1;
        tick();
        chk("a1 c1 ack_a", ifc.ack_a, 0);
        chk("a1 c1 backup", fbs_backup, 0);
        tick();
        chk("a1 c2 ack_a", ifc.ack_a, 1);
        chk("a1 c2 backup", fbs_backup, 1);
        chk("a1 c2 sel", fbs_sel, 0);
        chk("a1 c2 depth", depth, 1);
        chk("a1 c2 empty", empty, 0);
        chk("a1 c2 err", ifc.err, 0);
        shadow.push_back(frame_a);
        tick();
        chk("a1 c3 ack_a", ifc.ack_a, 0);
        chk("a1 c3 backup", fbs_backup, 0);
        ifc.req_a = 1'b0;
        tick();
        tick();
        chk("a1 no regrant backup", fbs_backup, 0);
        chk("a1 no regrant depth", depth, 1);

        // two B pushes, then A restore cycle by cycle
        do_op(1'b1, 1'b0, 1'b0, {8{32'hB0B0_0001}}, "b push1");
        do_op(1'b1, 1'b0, 1'b0, {8{32'hB0B0_0002}}, "b push2");
        chk("three pushed depth", depth, 3);
        ifc.op_a = 1'b1; ifc.req_a = 1'b1;
        tick();
        chk("pop c1 restore", fbs_restore, 0);
        tick();
        chk("pop c2 restore", fbs_restore, 1);
        chk("pop c2 ack_a", ifc.ack_a, 0);
        chk("pop c2 depth", depth, 2);
        tick();
        chk("pop c3 ack_a", ifc.ack_a, 1);
        chk("pop c3 rd_valid", ifc.rd_valid, 1);
        chk("pop c3 restore", fbs_restore, 0);
        chk("pop c3 err", ifc.err, 0);
        chk("pop c3 data", rd_dat, {8{32'hB0B0_0002}});
        void'(shadow.pop_back());
        tick();
        ifc.req_a = 1'b0;

        // round robin with both requesters continuously backing up
        do_reset();
        frame_a = {8{32'hAAAA_0000}};
        frame_b = {8{32'hBBBB_0000}};
        ifc.op_a = 1'b0; ifc.op_b = 1'b0;
        ifc.req_a = 1'b1; ifc.req_b = 1'b1;
        acks = 0;
        for (int k = 0; k < 40 && acks < 4; k++) begin
            tick();
            if (ifc.ack_a || ifc.ack_b) begin
                exp_id = (acks % 2) == 1;
                chk("rr ack_b is expected id", ifc.ack_b, exp_id);
                chk("rr sel", fbs_sel, exp_id);
                acks++;
                if (acks == 4) begin
                    ifc.req_a = 1'b0;
                    ifc.req_b = 1'b0;
                end
            end
        end
        chk("rr grant count", acks, 4);
        tick();
        tick();
        chk("rr depth", depth, 4);

        // push 5, pop 3, push 1, then fill and overflow, drain and underflow
        do_reset();
        for (int i = 0; i < 5; i++)
            do_op((i % 2) == 1, 1'b0, 1'b0, {8{32'hC000_0000 + i}}, "s push");
        for (int i = 0; i < 3; i++)
            do_op(1'b0, 1'b1, 1'b0, '0, "s pop");
        do_op(1'b1, 1'b0, 1'b0, {8{32'hC000_0100}}, "s push2");
        chk("s depth", depth, 3);
`ifdef FBS_CTRL_STATS_EN
        chk("s hwm", hwm, 5);
        chk("s rej_cnt zero", rej_cnt, 0);
`endif
        for (int i = 0; i < 13; i++)
            do_op((i % 2) == 1, 1'b0, 1'b0, {8{32'hD000_0000 + i}}, "fill");
        chk("fill depth", depth, 16);
        chk("fill full", full, 1);
        do_op(1'b0, 1'b0, 1'b1, {8{32'hDEAD_0000}}, "overflow");
        chk("overflow depth", depth, 16);
`ifdef FBS_CTRL_STATS_EN
        chk("overflow rej_cnt", rej_cnt, 1);
        chk("overflow hwm", hwm, 16);
`endif
        for (int i = 0; i < 16; i++)
            do_op((i % 2) == 1, 1'b1, 1'b0, '0, "drain");
        chk("drain depth", depth, 0);
        chk("drain empty", empty, 1);
        do_op(1'b1, 1'b1, 1'b1, '0, "underflow");
        chk("underflow depth", depth, 0);
`ifdef FBS_CTRL_STATS_EN
        chk("underflow rej_cnt", rej_cnt, 2);
`endif

        // reset during RDWAIT aborts the restore
        do_op(1'b0, 1'b0, 1'b0, {8{32'hE000_0001}}, "pre push1");
        do_op(1'b0, 1'b0, 1'b0, {8{32'hE000_0002}}, "pre push2");
        ifc.op_a = 1'b1; ifc.req_a = 1'b1;
        tick();
        tick();
        chk("abort strobe", fbs_restore, 1);
        rst_n = 1'b0;
        ifc.req_a = 1'b0;
        tick();
        chk("abort ack_a", ifc.ack_a, 0);
        chk("abort rd_valid", ifc.rd_valid, 0);
        chk("abort depth", depth, 0);
        rst_n = 1'b1;
        shadow.delete();
        tick();
        chk("abort late ack_a", ifc.ack_a, 0);
        chk("abort late rd_valid", ifc.rd_valid, 0);
        do_op(1'b0, 1'b0, 1'b0, {8{32'hF000_0001}}, "post push");
        chk("post depth", depth, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fbs_ctrl.md
Name: fbs_ctrl

Overview:
- Sequencer and arbiter for the 256-bit f-register backup stack (`fbs`).
- Two requesters share the stack: A, the call/return unit, and B, the trap unit. Each issues backup or restore operations over a req/ack handshake.
- The block arbitrates round-robin, tracks stack depth, and rejects overflow and underflow.
- It drives the stack's one-cycle backup/restore strobes and the data-in select, and returns restored frames with a valid pulse.

Parameters:
- DEPTH, 16, maximum number of frames held in the stack.
- DEPTH_W, 5, width of the depth counter; must hold 0..DEPTH.
- RD_LAT, 1, cycles from the restore strobe to restored data valid at the stack output (legal range 0..3).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_a  in  1  requester A operation request; held until ack_a.
- op_a  in  1  requester A operation: 0 = backup, 1 = restore; stable while req_a is high.
- req_b  in  1  requester B request; same rules as A.
- op_b  in  1  requester B operation; same encoding as op_a.
- ack_a  out  1  one-cycle completion pulse to A.
- ack_b  out  1  one-cycle completion pulse to B.
- err  out  1  qualifies an ack: 1 = rejected (overflow/underflow), no stack access made.
- fbs_backup  out  1  backup strobe to the stack; exactly one cycle per accepted backup.
- fbs_restore  out  1  restore strobe to the stack; exactly one cycle per accepted restore.
- fbs_sel  out  1  data-in select to the stack: 0 = A's frame, 1 = B's frame; valid while fbs_backup is high.
- rd_valid  out  1  restored frame on the stack output is valid this cycle; coincides with the ack of that restore.
- depth  out  DEPTH_W  current number of frames stacked.
- full  out  1  high when depth == DEPTH.
- empty  out  1  high when depth == 0.

Behaviour:
- Reset (rst_n low at posedge):
  - State goes to IDLE, depth = 0, round-robin pointer = A.
  - All strobes, acks, err and rd_valid are 0; fbs_sel = 0.
  - Reset aborts any in-flight operation with no ack.
  - The stack's own pointer is cleared by the same system reset.
- States: IDLE, GRANT, RDWAIT.
- IDLE:
  - If exactly one request is pending, grant it.
  - If both are pending, grant the requester named by the pointer; the pointer then flips to the other requester.
  - A single request also sets the pointer to the other requester.
  - Latch the granted id and op, then go to GRANT.
- GRANT, backup with depth < DEPTH:
  - fbs_backup = 1 and fbs_sel = the granted id.
  - depth increments; ack is pulsed in the same cycle.
  - Return to IDLE.
- GRANT, restore with depth > 0:
  - fbs_restore = 1 and depth decrements.
  - If RD_LAT = 0: ack and rd_valid pulse in the same cycle, then IDLE.
  - Otherwise go to RDWAIT.
- GRANT, backup when full or restore when empty:
  - No strobe is issued and depth is unchanged.
  - ack and err pulse together; return to IDLE.
- RDWAIT:
  - Count RD_LAT cycles after the strobe cycle.
  - On the last count, pulse ack together with rd_valid, then IDLE.
- Request handling:
  - Requests are sampled only in IDLE. A new grant can therefore issue earliest in the cycle after an ack.
  - Requests raised during GRANT or RDWAIT wait; they are never dropped.
  - The requester must drop req in the cycle after its ack, or the request is treated as new.
- Invariants:
  - At most one of fbs_backup / fbs_restore is high in any cycle.
  - At most one ack is high in any cycle.
  - depth never wraps: it saturates logically through the reject path.
  - full and empty are decoded combinationally from the registered depth.
- Latency:
  - Backup: 2 cycles from req to ack.
  - Restore: 2 + RD_LAT cycles from req to ack.

Optional Feature:
- Macro: FBS_CTRL_STATS_EN.
- Defined:
  - Adds output hwm [DEPTH_W-1:0], the high-water mark of depth since reset, updated on every depth increment.
  - Adds output rej_cnt [7:0], counting err acks; it saturates at 255.
  - Both outputs reset to 0.
- Undefined: neither port exists and no counter logic is built; all other behaviour is identical.

Test Plan:
- Reset, then A backup: ack_a in cycle 2, fbs_backup=1 for one cycle with fbs_sel=0, depth=1, empty=0.
- Push 3 frames, then restore (RD_LAT=1): fbs_restore in cycle 2, ack_a + rd_valid in cycle 3, depth 3→2, and the restored frame is the last one pushed.
- req_a and req_b both high continuously, both backup: grants alternate A,B,A,B starting with A after reset; no cycle has two acks.
- DEPTH=16 and full: backup gives ack + err, no fbs_backup, depth stays 16. Empty, then restore: ack + err, no fbs_restore, depth stays 0.
- Assert rst_n=0 during RDWAIT: next cycle is IDLE, depth=0, no ack and no rd_valid for the aborted op.
- With FBS_CTRL_STATS_EN: push 5, pop 3, push 1 → hwm=5; one overflow-rejected push after filling → rej_cnt=1.
